beta_exe_mc_sequencer: RTL and testbench

Parametrised execute-stage sequencer for multicycle operative units (shifter, LSU, future mul/div). It buffers decoded instructions in a small control FIFO and dispatches them one at a time to one of NumUnits units over an en/busy handshake. It generates the register-write pulse and the stage-busy flag. A watchdog aborts hung operations, and sticky error flags report overflow, timeout and illegal selects. It sits between the decode-stage handshake and the exe operative units.

---
 rtl/beta_exe_mc_sequencer_if.sv | 30 +++
 rtl/beta_exe_mc_sequencer.sv | 179 +++++++++++++++++
 tb/tb_beta_exe_mc_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/beta_exe_mc_sequencer_if.sv
// Decode-to-execute handshake bundle for the multicycle sequencer: instruction push,
// per-unit en/busy handshake, write-back pulse and status.
interface beta_exe_mc_sequencer_if #(
  parameter int NumUnits  = 4,
  parameter int PendDepth = 2
);
  logic                             exe_new_instr_i;
  logic [NumUnits-1:0]              exe_unit_sel_i;
  logic                             exe_reg_wr_en_i;
  logic [NumUnits-1:0]              exe_unit_busy_i;
  logic [NumUnits-1:0]              exe_unit_en_o;
  logic [NumUnits-1:0]              exe_active_unit_o;
  logic                             exe_reg_wr_en_o;
  logic                             exe_stage_busy_o;
  logic [$clog2(PendDepth+1)-1:0]   exe_pend_cnt_o;
  logic                             exe_pend_full_o;
  logic [2:0]                       exe_err_o;

  modport master (
    output exe_new_instr_i, exe_unit_sel_i, exe_reg_wr_en_i, exe_unit_busy_i,
    input  exe_unit_en_o, exe_active_unit_o, exe_reg_wr_en_o, exe_stage_busy_o,
           exe_pend_cnt_o, exe_pend_full_o, exe_err_o
  );

  modport slave (
    input  exe_new_instr_i, exe_unit_sel_i, exe_reg_wr_en_i, exe_unit_busy_i,
    output exe_unit_en_o, exe_active_unit_o, exe_reg_wr_en_o, exe_stage_busy_o,
           exe_pend_cnt_o, exe_pend_full_o, exe_err_o
  );
endinterface

// File: rtl/beta_exe_mc_sequencer.sv
// Execute-stage sequencer: buffers decoded instructions in a small FIFO and runs them one at
// a time on multicycle units over en/busy, with watchdog abort and sticky error flags.
module beta_exe_mc_sequencer #(
  parameter int NumUnits      = 4,
  parameter int PendDepth     = 2,
  parameter int TimeoutCycles = 64
) (
  input logic                    clk_i,
  input logic                    rst_i,
  beta_exe_mc_sequencer_if.slave bus
);
  localparam int CntW = $clog2(PendDepth + 1);
  localparam int PtrW = (PendDepth > 1) ? $clog2(PendDepth) : 1;
  localparam int WdW  = $clog2(TimeoutCycles + 1);
  localparam int EntW = NumUnits + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_WRITE     = 2'd3
  } state_t;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(PendDepth - 1)) begin
      return '0;
    end else begin
      return p + PtrW'(1);
    end
  endfunction

  // 0: no unit (single-cycle op), 1: exactly one unit, 2: illegal multi-hot
  function automatic logic [1:0] sel_class(input logic [NumUnits-1:0] sel);
    int ones;
    ones = $countones(sel);
    if (ones == 32'sd0) begin
      return 2'd0;
    end else if (ones == 32'sd1) begin
      return 2'd1;
    end else begin
      return 2'd2;
    end
  endfunction

  state_t              r_state;
  logic [EntW-1:0]     r_fifo [PendDepth];
  logic [PtrW-1:0]     r_wr_ptr;
  logic [PtrW-1:0]     r_rd_ptr;
  logic [CntW-1:0]     r_cnt;
  logic [NumUnits-1:0] r_sel;
  logic                r_wr_en;
  logic [WdW-1:0]      r_wd;
  logic [NumUnits-1:0] r_unit_en;
  logic [NumUnits-1:0] r_active;
  logic                r_reg_wr;
  logic [2:0]          r_err;

  logic                w_pop;
  logic                w_push;
  logic                w_overflow;
  logic [EntW-1:0]     w_head;
  logic [NumUnits-1:0] w_head_sel;
  logic                w_head_wr;
  logic                w_busy_sel;
  logic                w_timeout;

  assign w_pop      = (r_state == S_IDLE) && (r_cnt != '0);
  assign w_push     = bus.exe_new_instr_i && ((r_cnt < CntW'(PendDepth)) || w_pop);
  assign w_overflow = bus.exe_new_instr_i && !w_push;
  assign w_head     = r_fifo[r_rd_ptr];
  assign w_head_sel = w_head[EntW-1:1];
  assign w_head_wr  = w_head[0];
  // Only the owned unit's busy line matters; the others are masked off here.
  assign w_busy_sel = |(bus.exe_unit_busy_i & r_sel);
  assign w_timeout  = (r_wd == WdW'(TimeoutCycles - 1));

  // Pending-instruction FIFO: pointers wrap modulo depth, no bypass to the FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < PendDepth; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= {bus.exe_unit_sel_i, bus.exe_reg_wr_en_i};
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CntW'(1);
        2'b01:   r_cnt <= r_cnt - CntW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Control FSM with registered unit enable, ownership, write-back pulse, watchdog and errors
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_wr_en   <= 1'b0;
      r_wd      <= '0;
      r_unit_en <= '0;
      r_active  <= '0;
      r_reg_wr  <= 1'b0;
      r_err     <= 3'b000;
    end else begin
      r_reg_wr <= 1'b0;
      if (w_overflow) begin
        r_err[0] <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_sel   <= w_head_sel;
            r_wr_en <= w_head_wr;
            case (sel_class(w_head_sel))
              2'd0: begin
                r_state  <= S_WRITE;
                r_reg_wr <= w_head_wr;
              end
              2'd1: begin
                r_state   <= S_ISSUE;
                r_unit_en <= w_head_sel;
                r_active  <= w_head_sel;
                r_wd      <= '0;
              end
              default: r_err[2] <= 1'b1;
            endcase
          end
        end
        S_ISSUE: begin
          // The watchdog wins over a same-cycle acknowledge so an abort is never masked.
          if (w_timeout) begin
            r_err[1]  <= 1'b1;
            r_unit_en <= '0;
            r_active  <= '0;
            r_state   <= S_IDLE;
          end else if (w_busy_sel) begin
            r_unit_en <= '0;
            r_wd      <= r_wd + WdW'(1);
            r_state   <= S_WAIT_DONE;
          end else begin
            r_wd <= r_wd + WdW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (w_timeout) begin
            r_err[1] <= 1'b1;
            r_active <= '0;
            r_state  <= S_IDLE;
          end else if (!w_busy_sel) begin
            r_active <= '0;
            r_reg_wr <= r_wr_en;
            r_state  <= S_WRITE;
          end else begin
            r_wd <= r_wd + WdW'(1);
          end
        end
        S_WRITE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.exe_unit_en_o     = r_unit_en;
  assign bus.exe_active_unit_o = r_active;
  assign bus.exe_reg_wr_en_o   = r_reg_wr;
  assign bus.exe_err_o         = r_err;
  assign bus.exe_pend_cnt_o    = r_cnt;
  assign bus.exe_pend_full_o   = (r_cnt == CntW'(PendDepth));
  assign bus.exe_stage_busy_o  = (r_state != S_IDLE) || (r_cnt != '0);
endmodule

// File: tb/tb_beta_exe_mc_sequencer.sv
// Bench for beta_exe_mc_sequencer: directed vector table, hand-written corner sequences and
// a randomized run against a queue-based behavioural model.
module tb_beta_exe_mc_sequencer;
  localparam int NU    = 4;
  localparam int DEPTH = 2;
  localparam int TMO   = 12;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  beta_exe_mc_sequencer_if #(.NumUnits(NU), .PendDepth(DEPTH)) bus ();

  beta_exe_mc_sequencer #(.NumUnits(NU), .PendDepth(DEPTH), .TimeoutCycles(TMO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ni;
    logic [3:0] sel;
    logic       wr;
    logic [3:0] busy;
    logic [3:0] en;
    logic [3:0] act;
    logic       rw;
    logic       sb;
    logic [1:0] cnt;
    logic [2:0] err;
  } vec_t;

  typedef struct {
    logic [3:0] sel;
    logic       wr;
  } ent_t;

  vec_t tbl[$];

  // behavioural model state
  ent_t       mq[$];
  logic [3:0] m_owner;
  bit         m_granted;
  int         m_elapsed;
  logic       m_cur_wr;
  bit         m_wb;
  logic       m_wbwr;
  logic [2:0] m_err;

  function automatic vec_t mk(input logic ni, input logic [3:0] sel, input logic wr,
                              input logic [3:0] busy, input logic [3:0] en, input logic [3:0] act,
                              input logic rw, input logic sb, input logic [1:0] cnt,
                              input logic [2:0] err);
    vec_t v;
    v.ni = ni; v.sel = sel; v.wr = wr; v.busy = busy;
    v.en = en; v.act = act; v.rw = rw; v.sb = sb; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  task automatic cmp(input string nm, input string fld, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s at %0t: got %0h, expected %0h", nm, fld, $time, got, exp);
    end
  endtask

  task automatic chk(input string nm, input logic [3:0] en, input logic [3:0] act,
                     input logic rw, input logic sb, input logic [1:0] cnt, input logic [2:0] err);
    cmp(nm, "en",   32'(bus.exe_unit_en_o),     32'(en));
    cmp(nm, "act",  32'(bus.exe_active_unit_o), 32'(act));
    cmp(nm, "rw",   32'(bus.exe_reg_wr_en_o),   32'(rw));
    cmp(nm, "sb",   32'(bus.exe_stage_busy_o),  32'(sb));
    cmp(nm, "cnt",  32'(bus.exe_pend_cnt_o),    32'(cnt));
    cmp(nm, "full", 32'(bus.exe_pend_full_o),   32'(cnt == 2'd2));
    cmp(nm, "err",  32'(bus.exe_err_o),         32'(err));
  endtask

  // drive this cycle's inputs, then move to the next cycle's sampling point
  task automatic step(input logic ni, input logic [3:0] sel, input logic wr, input logic [3:0] busy);
    bus.exe_new_instr_i = ni;
    bus.exe_unit_sel_i  = sel;
    bus.exe_reg_wr_en_i = wr;
    bus.exe_unit_busy_i = busy;
    @(negedge clk);
  endtask

  task automatic model_reset();
    mq.delete();
    m_owner = 4'd0; m_granted = 1'b0; m_elapsed = 0; m_cur_wr = 1'b0;
    m_wb = 1'b0; m_wbwr = 1'b0; m_err = 3'b000;
  endtask

  // advance the model by one clock given this cycle's inputs
  task automatic model_step(input logic ni, input logic [3:0] sel, input logic wr,
                            input logic [3:0] busy);
    bit   idle;
    bit   pop;
    bit   acc;
    ent_t e;
    int   ones;
    idle = (m_owner == 4'd0) && !m_wb;
    pop  = idle && (mq.size() > 0);
    acc  = ni && ((mq.size() < DEPTH) || pop);
    if (ni && !acc) m_err[0] = 1'b1;
    if (m_wb) begin
      m_wb = 1'b0;
    end else if (m_owner != 4'd0) begin
      m_elapsed++;
      if (m_elapsed >= TMO) begin
        m_err[1] = 1'b1;
        m_owner  = 4'd0;
      end else if (!m_granted) begin
        if ((busy & m_owner) != 4'd0) m_granted = 1'b1;
      end else if ((busy & m_owner) == 4'd0) begin
        m_wb    = 1'b1;
        m_wbwr  = m_cur_wr;
        m_owner = 4'd0;
      end
    end else if (pop) begin
      e    = mq.pop_front();
      ones = $countones(e.sel);
      if (ones == 0) begin
        m_wb   = 1'b1;
        m_wbwr = e.wr;
      end else if (ones == 1) begin
        m_owner   = e.sel;
        m_cur_wr  = e.wr;
        m_granted = 1'b0;
        m_elapsed = 0;
      end else begin
        m_err[2] = 1'b1;
      end
    end
    if (acc) begin
      e.sel = sel;
      e.wr  = wr;
      mq.push_back(e);
    end
  endtask

  initial begin
    int         bias;
    int         r;
    logic       ni;
    logic [3:0] sel;
    logic       wr;
    logic [3:0] busy;
    logic [3:0] m_en;
    int         bias_tab [4];

    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.exe_new_instr_i = 1'b0;
    bus.exe_unit_sel_i  = 4'd0;
    bus.exe_reg_wr_en_i = 1'b0;
    bus.exe_unit_busy_i = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset", 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 3'b000);

    // single-cycle op
    tbl.push_back(mk(1, 4'd0, 1, 4'd0,    4'd0, 4'd0, 0, 0, 2'd0, 3'b000));
    tbl.push_back(mk(0, 4'd0, 0, 4'd0,    4'd0, 4'd0, 0, 1, 2'd1, 3'b000));
    tbl.push_back(mk(0, 4'd0, 0, 4'd0,    4'd0, 4'd0, 1, 1, 2'd0, 3'b000));
    tbl.push_back(mk(0, 4'd0, 0, 4'd0,    4'd0, 4'd0, 0, 0, 2'd0, 3'b000));
    // multicycle op on unit 1, busy cycles 4..9, noise on other units
    tbl.push_back(mk(1, 4'd2, 1, 4'd0,    4'd0, 4'd0, 0, 0, 2'd0, 3'b000));
    tbl.push_back(mk(0, 4'd0, 0, 4'd0,    4'd0, 4'd0, 0, 1, 2'd1, 3'b000));
    tbl.push_back(mk(0, 4'd0, 0, 4'b1100, 4'd2, 4'd2, 0, 1, 2'd0, 3'b000));
    tbl.push_back(mk(0, 4'd0, 0, 4'd0,    4'd2, 4'd2, 0, 1, 2'd0, 3'b000));
    tbl.push_back(mk(0, 4'd0, 0, 4'd2,    4'd2, 4'd2, 0, 1, 2'd0, 3'b000));
    for (int i = 5; i <= 9; i++) tbl.push_back(mk(0, 4'd0, 0, 4'd2, 4'd0, 4'd2, 0, 1, 2'd0, 3'b000));
    tbl.push_back(mk(0, 4'd0, 0, 4'b1101, 4'd0, 4'd2, 0, 1, 2'd0, 3'b000));
    tbl.push_back(mk(0, 4'd0, 0, 4'd0,    4'd0, 4'd0, 1, 1, 2'd0, 3'b000));
    tbl.push_back(mk(0, 4'd0, 0, 4'd0,    4'd0, 4'd0, 0, 0, 2'd0, 3'b000));
    // multicycle op on unit 0 with wr=0: no write pulse
    tbl.push_back(mk(1, 4'd1, 0, 4'd0,    4'd0, 4'd0, 0, 0, 2'd0, 3'b000));
    tbl.push_back(mk(0, 4'd0, 0, 4'd0,    4'd0, 4'd0, 0, 1, 2'd1, 3'b000));
    tbl.push_back(mk(0, 4'd0, 0, 4'b1110, 4'd1, 4'd1, 0, 1, 2'd0, 3'b000));
    tbl.push_back(mk(0, 4'd0, 0, 4'd1,    4'd1, 4'd1, 0, 1, 2'd0, 3'b000));
    tbl.push_back(mk(0, 4'd0, 0, 4'd0,    4'd0, 4'd1, 0, 1, 2'd0, 3'b000));
    tbl.push_back(mk(0, 4'd0, 0, 4'd0,    4'd0, 4'd0, 0, 1, 2'd0, 3'b000));
    tbl.push_back(mk(0, 4'd0, 0, 4'd0,    4'd0, 4'd0, 0, 0, 2'd0, 3'b000));
    // illegal multi-hot select
    tbl.push_back(mk(1, 4'd3, 1, 4'd0,    4'd0, 4'd0, 0, 0, 2'd0, 3'b000));
    tbl.push_back(mk(0, 4'd0, 0, 4'd0,    4'd0, 4'd0, 0, 1, 2'd1, 3'b000));
    tbl.push_back(mk(0, 4'd0, 0, 4'd0,    4'd0, 4'd0, 0, 0, 2'd0, 3'b100));
    tbl.push_back(mk(0, 4'd0, 0, 4'd0,    4'd0, 4'd0, 0, 0, 2'd0, 3'b100));

    foreach (tbl[i]) begin
      chk($sformatf("vec%0d", i), tbl[i].en, tbl[i].act, tbl[i].rw, tbl[i].sb, tbl[i].cnt, tbl[i].err);
      step(tbl[i].ni, tbl[i].sel, tbl[i].wr, tbl[i].busy);
    end

    // reset in the middle of an operation (unit 1 in WAIT_DONE, one entry buffered)
    step(1, 4'd2, 1, 4'd0);
    step(0, 4'd0, 0, 4'd0);
    chk("rst_issue", 4'd2, 4'd2, 0, 1, 2'd0, 3'b100);
    step(0, 4'd0, 0, 4'd2);
    chk("rst_wait", 4'd0, 4'd2, 0, 1, 2'd0, 3'b100);
    step(1, 4'd1, 1, 4'd2);
    chk("rst_pre", 4'd0, 4'd2, 0, 1, 2'd1, 3'b100);
    rst = 1'b1;
    step(0, 4'd0, 0, 4'd2);
    rst = 1'b0;
    chk("rst_mid", 4'd0, 4'd0, 0, 0, 2'd0, 3'b000);
    step(0, 4'd0, 0, 4'd2);
    chk("rst_after", 4'd0, 4'd0, 0, 0, 2'd0, 3'b000);

    // overflow: unit 0 stalled busy, three more pushes, third is dropped
    step(1, 4'd1, 1, 4'd0);
    step(0, 4'd0, 0, 4'd0);
    chk("ovf_issue", 4'd1, 4'd1, 0, 1, 2'd0, 3'b000);
    step(0, 4'd0, 0, 4'd1);
    step(1, 4'd0, 1, 4'd1);
    step(1, 4'd4, 0, 4'd1);
    chk("ovf_full", 4'd0, 4'd1, 0, 1, 2'd2, 3'b000);
    step(1, 4'd2, 1, 4'd1);
    chk("ovf_err", 4'd0, 4'd1, 0, 1, 2'd2, 3'b001);
    step(0, 4'd0, 0, 4'd0);
    chk("ovf_wb_a", 4'd0, 4'd0, 1, 1, 2'd2, 3'b001);
    step(0, 4'd0, 0, 4'd0);
    chk("ovf_idle", 4'd0, 4'd0, 0, 1, 2'd2, 3'b001);
    step(0, 4'd0, 0, 4'd0);
    chk("ovf_wb_b", 4'd0, 4'd0, 1, 1, 2'd1, 3'b001);
    step(0, 4'd0, 0, 4'd0);
    chk("ovf_idle2", 4'd0, 4'd0, 0, 1, 2'd1, 3'b001);
    step(0, 4'd0, 0, 4'd0);
    chk("ovf_issue_c", 4'd4, 4'd4, 0, 1, 2'd0, 3'b001);
    step(0, 4'd0, 0, 4'd4);
    chk("ovf_wait_c", 4'd0, 4'd4, 0, 1, 2'd0, 3'b001);
    step(0, 4'd0, 0, 4'd0);
    chk("ovf_wb_c", 4'd0, 4'd0, 0, 1, 2'd0, 3'b001);
    step(0, 4'd0, 0, 4'd0);
    chk("ovf_done", 4'd0, 4'd0, 0, 0, 2'd0, 3'b001);

    // timeout: unit 2 never busy, other units busy (ignored), next entry dispatched after abort
    step(1, 4'd4, 1, 4'b1011);
    chk("tmo_pop", 4'd0, 4'd0, 0, 1, 2'd1, 3'b001);
    step(1, 4'd0, 1, 4'b1011);
    for (int i = 0; i < TMO; i++) begin
      chk("tmo_wait", 4'd4, 4'd4, 0, 1, 2'd1, 3'b001);
      step(0, 4'd0, 0, 4'b1011);
    end
    chk("tmo_abort", 4'd0, 4'd0, 0, 1, 2'd1, 3'b011);
    step(0, 4'd0, 0, 4'b1011);
    chk("tmo_next", 4'd0, 4'd0, 1, 1, 2'd0, 3'b011);
    step(0, 4'd0, 0, 4'd0);
    chk("tmo_done", 4'd0, 4'd0, 0, 0, 2'd0, 3'b011);

    // randomized run against the behavioural model
    rst = 1'b1;
    step(0, 4'd0, 0, 4'd0);
    rst = 1'b0;
    model_reset();
    bias_tab[0] = 5; bias_tab[1] = 50; bias_tab[2] = 95; bias_tab[3] = 30;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      m_en = (m_owner != 4'd0 && !m_granted) ? m_owner : 4'd0;
      chk("rand", m_en, m_owner, m_wb && m_wbwr,
          (m_owner != 4'd0) || m_wb || (mq.size() > 0), 2'(mq.size()), m_err);
      bias = bias_tab[(cyc / 250) % 4];
      ni   = ($urandom_range(0, 99) < 35);
      r    = int'($urandom_range(0, 9));
      if (r < 2) sel = 4'd0;
      else if (r < 9) sel = 4'd1 << $urandom_range(0, 3);
      else sel = 4'd3 << $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      for (int u = 0; u < NU; u++) busy[u] = ($urandom_range(0, 99) < bias);
      model_step(ni, sel, wr, busy);
      step(ni, sel, wr, busy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
